idu_queue: RTL and testbench



---
 rtl/idu_pkg.sv | 291 +++++++++++++++++++++++++++++
 rtl/idu_fifo.sv | 55 +++++
 rtl/idu_queue.sv | 106 ++++++++++
 tb/tb_idu_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// idu_pkg: shared types, opcode constants and the RV32I instruction decoder
// for the idu_queue decode stage.
// Optional feature macro: IDU_ZICSR_EN enables CSR instructions and mret.
// Without it those words decode as illegal.
package idu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CSR_W = 12;

    typedef enum logic [5:0] {
        OP_NOP    = 6'd0,
        OP_ILL    = 6'd1,
        OP_ADD    = 6'd2,
        OP_SUB    = 6'd3,
        OP_SLL    = 6'd4,
        OP_SLT    = 6'd5,
        OP_SLTU   = 6'd6,
        OP_XOR    = 6'd7,
        OP_SRL    = 6'd8,
        OP_SRA    = 6'd9,
        OP_OR     = 6'd10,
        OP_AND    = 6'd11,
        OP_ADDI   = 6'd12,
        OP_SLTI   = 6'd13,
        OP_SLTIU  = 6'd14,
        OP_XORI   = 6'd15,
        OP_ORI    = 6'd16,
        OP_ANDI   = 6'd17,
        OP_SLLI   = 6'd18,
        OP_SRLI   = 6'd19,
        OP_SRAI   = 6'd20,
        OP_LUI    = 6'd21,
        OP_AUIPC  = 6'd22,
        OP_JAL    = 6'd23,
        OP_JALR   = 6'd24,
        OP_BEQ    = 6'd25,
        OP_BNE    = 6'd26,
        OP_BLT    = 6'd27,
        OP_BGE    = 6'd28,
        OP_BLTU   = 6'd29,
        OP_BGEU   = 6'd30,
        OP_LB     = 6'd31,
        OP_LH     = 6'd32,
        OP_LW     = 6'd33,
        OP_LBU    = 6'd34,
        OP_LHU    = 6'd35,
        OP_SB     = 6'd36,
        OP_SH     = 6'd37,
        OP_SW     = 6'd38,
        OP_ECALL  = 6'd39,
        OP_EBREAK = 6'd40,
        OP_MRET   = 6'd41,
        OP_CSRRW  = 6'd42,
        OP_CSRRS  = 6'd43,
        OP_CSRRC  = 6'd44,
        OP_CSRRWI = 6'd45,
        OP_CSRRSI = 6'd46,
        OP_CSRRCI = 6'd47
    } op_e;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Decoded operation bundle carried by the output register
    typedef struct packed {
        op_e              op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic             wen;
        logic [CSR_W-1:0] csr;
        logic             mem_rd;
        logic             mem_wr;
        mem_size_e        mem_size;
        logic             mem_uns;
        logic             illegal;
    } bundle_t;

    localparam bundle_t BUNDLE_RST = '{
        op:       OP_NOP,
        rd:       '0,
        rs1:      '0,
        rs2:      '0,
        imm:      '0,
        wen:      1'b0,
        csr:      '0,
        mem_rd:   1'b0,
        mem_wr:   1'b0,
        mem_size: MEM_B,
        mem_uns:  1'b0,
        illegal:  1'b0
    };

    // Pure decode of one instruction word; register fields an instruction
    // does not use are returned as zero, and an illegal word returns a
    // cleared bundle tagged OP_ILL.
    function automatic bundle_t decode(input logic [31:0] inst, input int unsigned nr_reg);
        bundle_t     b;
        logic        ill;
        logic        use_rd;
        logic        use_rs1;
        logic        use_rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        logic [31:0] shamt;

        b       = BUNDLE_RST;
        ill     = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        f3      = inst[14:12];
        f7      = inst[31:25];
        imm_i   = {{20{inst[31]}}, inst[31:20]};
        imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u   = {inst[31:12], 12'h000};
        imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        shamt   = 32'(inst[24:20]);

        case (inst[6:0])
            OPC_LUI: begin
                b.op = OP_LUI; b.imm = imm_u; use_rd = 1'b1;
            end
            OPC_AUIPC: begin
                b.op = OP_AUIPC; b.imm = imm_u; use_rd = 1'b1;
            end
            OPC_JAL: begin
                b.op = OP_JAL; b.imm = imm_j; use_rd = 1'b1;
            end
            OPC_JALR: begin
                b.op = OP_JALR; b.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
                ill = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                b.imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3)
                    3'b000:  b.op = OP_BEQ;
                    3'b001:  b.op = OP_BNE;
                    3'b100:  b.op = OP_BLT;
                    3'b101:  b.op = OP_BGE;
                    3'b110:  b.op = OP_BLTU;
                    3'b111:  b.op = OP_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                b.imm = imm_i; b.mem_rd = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                case (f3)
                    3'b000:  begin b.op = OP_LB;  b.mem_size = MEM_B; end
                    3'b001:  begin b.op = OP_LH;  b.mem_size = MEM_H; end
                    3'b010:  begin b.op = OP_LW;  b.mem_size = MEM_W; end
                    3'b100:  begin b.op = OP_LBU; b.mem_size = MEM_B; b.mem_uns = 1'b1; end
                    3'b101:  begin b.op = OP_LHU; b.mem_size = MEM_H; b.mem_uns = 1'b1; end
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                b.imm = imm_s; b.mem_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3)
                    3'b000:  begin b.op = OP_SB; b.mem_size = MEM_B; end
                    3'b001:  begin b.op = OP_SH; b.mem_size = MEM_H; end
                    3'b010:  begin b.op = OP_SW; b.mem_size = MEM_W; end
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                b.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
                case (f3)
                    3'b000: b.op = OP_ADDI;
                    3'b010: b.op = OP_SLTI;
                    3'b011: b.op = OP_SLTIU;
                    3'b100: b.op = OP_XORI;
                    3'b110: b.op = OP_ORI;
                    3'b111: b.op = OP_ANDI;
                    3'b001: begin
                        b.op = OP_SLLI; b.imm = shamt; ill = (f7 != F7_BASE);
                    end
                    default: begin
                        b.imm = shamt;
                        if (f7 == F7_BASE)     b.op = OP_SRLI;
                        else if (f7 == F7_ALT) b.op = OP_SRAI;
                        else                   ill = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  b.op = OP_ADD;
                        3'b001:  b.op = OP_SLL;
                        3'b010:  b.op = OP_SLT;
                        3'b011:  b.op = OP_SLTU;
                        3'b100:  b.op = OP_XOR;
                        3'b101:  b.op = OP_SRL;
                        3'b110:  b.op = OP_OR;
                        default: b.op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  b.op = OP_SUB;
                        3'b101:  b.op = OP_SRA;
                        default: ill = 1'b1;
                    endcase
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // fence carries no work for this core
                b.op = OP_NOP;
                ill  = (f3 != 3'b000);
            end
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    if (inst == INST_ECALL)       b.op = OP_ECALL;
                    else if (inst == INST_EBREAK) b.op = OP_EBREAK;
`ifdef IDU_ZICSR_EN
                    else if (inst == INST_MRET)   b.op = OP_MRET;
`endif
                    else                          ill = 1'b1;
                end else begin
`ifdef IDU_ZICSR_EN
                    b.csr  = inst[31:20];
                    use_rd = 1'b1;
                    case (f3)
                        3'b001:  begin b.op = OP_CSRRW; use_rs1 = 1'b1; end
                        3'b010:  begin b.op = OP_CSRRS; use_rs1 = 1'b1; end
                        3'b011:  begin b.op = OP_CSRRC; use_rs1 = 1'b1; end
                        3'b101:  begin b.op = OP_CSRRWI; b.imm = 32'(inst[19:15]); end
                        3'b110:  begin b.op = OP_CSRRSI; b.imm = 32'(inst[19:15]); end
                        3'b111:  begin b.op = OP_CSRRCI; b.imm = 32'(inst[19:15]); end
                        default: ill = 1'b1;
                    endcase
`else
                    ill = 1'b1;
`endif
                end
            end
            default: ill = 1'b1;
        endcase

        if (inst[1:0] != 2'b11)                      ill = 1'b1;
        if (use_rd  && (32'(inst[11:7])  >= nr_reg)) ill = 1'b1;
        if (use_rs1 && (32'(inst[19:15]) >= nr_reg)) ill = 1'b1;
        if (use_rs2 && (32'(inst[24:20]) >= nr_reg)) ill = 1'b1;

        if (ill) begin
            b         = BUNDLE_RST;
            b.op      = OP_ILL;
            b.illegal = 1'b1;
        end else begin
            b.rd  = use_rd  ? inst[11:7]  : 5'd0;
            b.rs1 = use_rs1 ? inst[19:15] : 5'd0;
            b.rs2 = use_rs2 ? inst[24:20] : 5'd0;
            b.wen = use_rd && (inst[11:7] != 5'd0);
        end
        return b;
    endfunction

endpackage

// File: rtl/idu_fifo.sv
// idu_fifo: DEPTH-entry circular queue with extra-MSB pointers.
// Ports: clk, rst_n (async, active-low), clr (sync clear of pointers),
//        push/wdata (write at tail), pop (advance head), rdata_c (head entry),
//        full_c, empty_c (status).
module idu_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same slot index with opposite lap bit means the writer is a full lap ahead
    assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty_c = (wr_ptr == rd_ptr);
    assign do_push = push && !full_c && !clr;
    assign do_pop  = pop && !empty_c && !clr;
    assign rdata_c = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear wins over any concurrent push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: entries are only visible between the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/idu_queue.sv
// idu_queue: RV32E/RV32I decode stage. Buffers fetched {pc, inst} pairs in
// an idu_fifo and decodes the head into a registered bundle with a
// valid/ready handshake toward the EXU.
// Optional feature macro: IDU_ZICSR_EN (CSR instructions and mret).
// Ports: clk, rst_n (async, active-low), flush (sync);
//        in_valid/in_ready/in_pc/in_inst from the IFU;
//        out_valid/out_ready and the decoded fields out_pc, out_op, out_rd,
//        out_rs1, out_rs2, out_imm, out_wen, out_csr, out_mem_rd,
//        out_mem_wr, out_mem_size, out_mem_uns, out_illegal to the EXU.
module idu_queue
    import idu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NR_REG = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [5:0]  out_op,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic        out_wen,
    output logic [11:0] out_csr,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic [1:0]  out_mem_size,
    output logic        out_mem_uns,
    output logic        out_illegal
);

    localparam int unsigned FIFO_W = 64;

    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              load_c;
    logic [FIFO_W-1:0] head_c;
    bundle_t           head_dec_c;

    logic              valid_q;
    logic [31:0]       pc_q;
    bundle_t           bundle_q;

    assign in_ready   = !full_c && !flush;
    assign push_c     = in_valid && in_ready;
    assign load_c     = (!valid_q || out_ready) && !empty_c && !flush;
    assign head_dec_c = decode(head_c[31:0], NR_REG);

    // Instruction queue; payload is {pc, inst}
    idu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .push    (push_c),
        .wdata   ({in_pc, in_inst}),
        .pop     (load_c),
        .rdata_c (head_c),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Output register: refills whenever free, drops valid when nothing to load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            bundle_q <= BUNDLE_RST;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!valid_q || out_ready) begin
            valid_q <= !empty_c;
            if (!empty_c) begin
                pc_q     <= head_c[63:32];
                bundle_q <= head_dec_c;
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_op       = bundle_q.op;
    assign out_rd       = bundle_q.rd;
    assign out_rs1      = bundle_q.rs1;
    assign out_rs2      = bundle_q.rs2;
    assign out_imm      = bundle_q.imm;
    assign out_wen      = bundle_q.wen;
    assign out_csr      = bundle_q.csr;
    assign out_mem_rd   = bundle_q.mem_rd;
    assign out_mem_wr   = bundle_q.mem_wr;
    assign out_mem_size = bundle_q.mem_size;
    assign out_mem_uns  = bundle_q.mem_uns;
    assign out_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_idu_queue.sv
// tb_idu_queue: directed bench for idu_queue. One instance uses NR_REG=16
// (RV32E), a second identical-stimulus instance uses NR_REG=32 (RV32I).
module tb_idu_queue;
    import idu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_inst;

    logic        in_ready, out_valid, out_wen, out_mem_rd, out_mem_wr, out_mem_uns, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [5:0]  out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [11:0] out_csr;
    logic [1:0]  out_mem_size;

    logic        in_ready_b, out_valid_b, out_wen_b, out_mem_rd_b, out_mem_wr_b, out_mem_uns_b, out_illegal_b;
    logic [31:0] out_pc_b, out_imm_b;
    logic [5:0]  out_op_b;
    logic [4:0]  out_rd_b, out_rs1_b, out_rs2_b;
    logic [11:0] out_csr_b;
    logic [1:0]  out_mem_size_b;

    int n_checks = 0;
    int n_err    = 0;
    int acc;

    always #5 clk = ~clk;

    idu_queue #(.DEPTH(4), .NR_REG(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_wen(out_wen), .out_csr(out_csr), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_mem_size(out_mem_size), .out_mem_uns(out_mem_uns), .out_illegal(out_illegal)
    );

    idu_queue #(.DEPTH(4), .NR_REG(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_op(out_op_b),
        .out_rd(out_rd_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_imm(out_imm_b),
        .out_wen(out_wen_b), .out_csr(out_csr_b), .out_mem_rd(out_mem_rd_b), .out_mem_wr(out_mem_wr_b),
        .out_mem_size(out_mem_size_b), .out_mem_uns(out_mem_uns_b), .out_illegal(out_illegal_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into an empty queue and wait for it to reach the output
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] addi_x1(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_op",    32'(out_op),    32'(OP_NOP));
        chk("rst_imm",   out_imm,        32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        issue(32'h8000_0000, 32'h0050_0093);
        chk("addi_valid", 32'(out_valid),   32'd1);
        chk("addi_pc",    out_pc,           32'h8000_0000);
        chk("addi_op",    32'(out_op),      32'(OP_ADDI));
        chk("addi_rd",    32'(out_rd),      32'd1);
        chk("addi_rs1",   32'(out_rs1),     32'd0);
        chk("addi_imm",   out_imm,          32'd5);
        chk("addi_wen",   32'(out_wen),     32'd1);
        chk("addi_ill",   32'(out_illegal), 32'd0);

        issue(32'h8000_0004, 32'h0011_2623);
        chk("sw_op",   32'(out_op),       32'(OP_SW));
        chk("sw_rs1",  32'(out_rs1),      32'd2);
        chk("sw_rs2",  32'(out_rs2),      32'd1);
        chk("sw_imm",  out_imm,           32'd12);
        chk("sw_mwr",  32'(out_mem_wr),   32'd1);
        chk("sw_size", 32'(out_mem_size), 32'd2);
        chk("sw_wen",  32'(out_wen),      32'd0);

        issue(32'h8000_0008, 32'h0000_08B3);
        chk("x17_e_ill", 32'(out_illegal),   32'd1);
        chk("x17_e_op",  32'(out_op),        32'(OP_ILL));
        chk("x17_e_wen", 32'(out_wen),       32'd0);
        chk("x17_i_op",  32'(out_op_b),      32'(OP_ADD));
        chk("x17_i_rd",  32'(out_rd_b),      32'd17);
        chk("x17_i_wen", 32'(out_wen_b),     32'd1);
        chk("x17_i_ill", 32'(out_illegal_b), 32'd0);

        issue(32'h8000_000C, 32'h0010_0073);
        chk("ebreak_op",  32'(out_op),      32'(OP_EBREAK));
        chk("ebreak_ill", 32'(out_illegal), 32'd0);

        issue(32'h8000_0010, 32'h3051_10F3);
`ifdef IDU_ZICSR_EN
        chk("csrrw_op",  32'(out_op),      32'(OP_CSRRW));
        chk("csrrw_csr", 32'(out_csr),     32'h305);
        chk("csrrw_rd",  32'(out_rd),      32'd1);
        chk("csrrw_wen", 32'(out_wen),     32'd1);
`else
        chk("csrrw_ill", 32'(out_illegal), 32'd1);
        chk("csrrw_op",  32'(out_op),      32'(OP_ILL));
        chk("csrrw_csr", 32'(out_csr),     32'd0);
`endif

        issue(32'h8000_0014, 32'hFE20_8EE3);
        chk("beq_op",  32'(out_op),  32'(OP_BEQ));
        chk("beq_imm", out_imm,      32'hFFFF_FFFC);
        chk("beq_rs2", 32'(out_rs2), 32'd2);

        issue(32'h8000_0018, 32'h4072_5193);
        chk("srai_op",  32'(out_op),  32'(OP_SRAI));
        chk("srai_imm", out_imm,      32'd7);
        chk("srai_rs1", 32'(out_rs1), 32'd4);

        issue(32'h8000_001C, 32'hFFF3_4283);
        chk("lbu_op",   32'(out_op),       32'(OP_LBU));
        chk("lbu_imm",  out_imm,           32'hFFFF_FFFF);
        chk("lbu_mrd",  32'(out_mem_rd),   32'd1);
        chk("lbu_uns",  32'(out_mem_uns),  32'd1);
        chk("lbu_size", 32'(out_mem_size), 32'd0);

        issue(32'h8000_0020, 32'h1234_50B7);
        chk("lui_imm", out_imm,      32'h1234_5000);
        chk("lui_wen", 32'(out_wen), 32'd1);
        issue(32'h8000_0024, 32'h1234_5037);
        chk("lui_x0_wen", 32'(out_wen), 32'd0);
        issue(32'h8000_0028, 32'h0050_0090);
        chk("bad_lsb_ill", 32'(out_illegal), 32'd1);

        // Back-to-back stream with the EXU always ready
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst  = addi_x1(12'(16 + i));
            tick();
            if (i > 0) chk("thru_imm", out_imm, 32'(16 + i - 1));
        end
        in_valid = 1'b0;
        tick();
        chk("thru_last", out_imm, 32'd19);
        tick();
        chk("thru_drained", 32'(out_valid), 32'd0);

        // Capacity with the EXU stalled
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_inst  = addi_x1(12'(acc + 1));
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("cap_accepted", 32'(acc),       32'd5);
        chk("cap_in_ready", 32'(in_ready),  32'd0);
        chk("cap_valid",    32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_imm",   out_imm,        32'(k));
            tick();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Flush with queued entries and a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_inst  = addi_x1(12'(33 + i));
            tick();
        end
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_inst = addi_x1(12'h02F);
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        tick();
        chk("flush_no_stale", 32'(out_valid), 32'd0);
        chk("flush_in_ready2", 32'(in_ready), 32'd1);
        issue(32'h8000_0100, addi_x1(12'h030));
        chk("post_flush_valid", 32'(out_valid), 32'd1);
        chk("post_flush_imm",   out_imm,        32'h30);
        tick();
        chk("post_flush_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_inst  = addi_x1(12'(64 + i));
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_op",    32'(out_op),    32'(OP_NOP));
        chk("arst_imm",   out_imm,        32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("arst_lost",     32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
